regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised successor to the integer register file, for the pipelined core.
- Provides NRD combinational read ports with same-cycle write bypass, and two write ports: writeback (WB) and load-return (LD).
- Includes a per-register busy scoreboard set at issue and cleared at write.
- Clears storage with a post-reset sweep FSM, so the array has no per-entry reset and maps to RAM-like logic.

Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of 2, >= 2)
- AW, $clog2(NREGS), register address width (derived, not overridden)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous and active-high
- init_done  out  1  high once the clear sweep has finished
- rs_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW]
- rs_data  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN]
- rs_busy  out  NRD  scoreboard busy flag per read port
- wb_en  in  1  WB write enable
- wb_addr  in  AW  WB destination
- wb_data  in  XLEN  WB data
- ld_en  in  1  LD write enable
- ld_addr  in  AW  LD destination
- ld_data  in  XLEN  LD data
- iss_en  in  1  mark iss_addr busy
- iss_addr  in  AW  issuing destination
- flush  in  1  clear all busy bits

Behaviour:
- FSM states: INIT, RUN.
- rst high at an edge: next state INIT, sweep counter 0, busy all 0, init_done 0. This applies at any time, including mid-RUN; the sweep restarts.
- INIT: each cycle writes 0 to reg[cnt], then cnt increments. Once reg[NREGS-1] is written, next state is RUN.
- init_done is registered: it rises NREGS cycles after the first edge with rst low, and is 1 only in RUN.
- During INIT:
  - wb_en, ld_en, iss_en and flush are ignored.
  - rs_data reads all zeros and rs_busy is 0.
- Array entries have no reset of their own; only the sweep clears them.
- Writes (RUN only) take effect at the clock edge.
  - Effective write: en=1, and addr!=0 when ZERO_REG=1.
  - WB and LD to the same address in the same cycle: WB data is stored and LD is dropped.
  - WB and LD to different addresses: both are stored.
- Reads are combinational, with zero latency.
  - ZERO_REG=1 and addr 0: data 0, busy 0.
  - Otherwise, if an effective WB write targets the read address this cycle: data is wb_data.
  - Otherwise, if an effective LD write targets the read address: data is ld_data.
  - Otherwise: data is the array contents.
- Scoreboard: busy[NREGS] register, updated at the edge in RUN.
  - Clear: busy[a] is cleared when an effective WB or LD write targets a.
  - Set: busy[iss_addr] is set when iss_en=1 and the address is not 0 under ZERO_REG.
  - Set and clear of the same address in the same cycle: set wins, because a new producer owns the register.
  - flush=1: busy becomes all zeros next cycle; this overrides any set or clear in the same cycle.
  - rs_busy[k] = busy[rs_addr_k] AND NOT (an effective write to rs_addr_k this cycle). This keeps it consistent with the bypassed data.
- Any number of read ports may use the same address; each gets an identical result.
- Reset values:
  - init_done = 0.
  - rs_busy = 0.
  - rs_data = 0 for the whole INIT phase.

Decomposition:
- The shared core package holds:
  - the FSM state enum (RF_INIT, RF_RUN);
  - the constant RF_ZERO_ADDR = 0.
- One sub-module, regfile_rd_bypass: a single read port that takes the address, array word, both write ports and the busy bit, and produces rs_data/rs_busy.
- The top instantiates regfile_rd_bypass NRD times in a generate loop.

Test Plan:
- Reset sweep: hold rst 3 cycles, then release. Required: init_done=0 for exactly 32 cycles, then 1. All 32 registers read 0. wb_en pulses during INIT leave the registers at 0.
- Write/read and bypass: wb writes x5=0xDEADBEEF. Same cycle: rs_addr0=5 returns 0xDEADBEEF. Next cycle: still returns it from the array. A write to x0 of 0x1234: x0 reads 0.
- Port collision: wb x7=0xAAAA0000 and ld x7=0x5555FFFF in the same cycle. Required: the combinational read returns 0xAAAA0000 and the next-cycle read returns 0xAAAA0000. wb x8 plus ld x9 in one cycle: both stored.
- Scoreboard: iss x3, then rs_busy=1 on x3. Later, ld x3=0x42 in the same cycle as iss x3: busy stays 1 (set wins) and data=0x42. Then wb x3 alone: busy=0.
- Flush: iss x1, x2, x4 on successive cycles, then flush together with iss x6. Required: next cycle busy is 0 for x1, x2, x4 and x6.
- Mid-run reset: write x10=0xFFFFFFFF, set busy on x11, assert rst for 1 cycle. Required: init_done drops, then rises 32 cycles later. x10 reads 0 and x11 is not busy. Repeat with NREGS=16, NRD=3: init_done rises after 16 cycles, and all three ports read a bypassed value correctly.

Source files
------------

// File: rtl/regfile_mp_sb_pkg.sv
// Shared definitions for the multi-port scoreboarded register file.
package regfile_mp_sb_pkg;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

  localparam int RF_ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_rd_bypass.sv
// One read port: zero-register masking, WB-over-LD write bypass, busy masking.
module regfile_rd_bypass
  import regfile_mp_sb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            run,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] arr_word,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ld_we,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data,
  input  logic            busy_bit,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_busy
);

  logic zero, wb_hit, ld_hit;

  assign zero   = (ZERO_REG != 0) && (rd_addr == AW'(RF_ZERO_ADDR));
  assign wb_hit = wb_we && (wb_addr == rd_addr);
  assign ld_hit = ld_we && (ld_addr == rd_addr);

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (run && !zero) begin
      if (wb_hit)      rd_data = wb_data;
      else if (ld_hit) rd_data = ld_data;
      else             rd_data = arr_word;
      // a write landing this cycle retires the producer, matching the bypassed data
      rd_busy = busy_bit && !(wb_hit || ld_hit);
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Register file with NRD bypassed read ports, WB/LD write ports, busy scoreboard
// and a post-reset clear sweep so the array itself carries no reset.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                ld_en,
  input  logic [AW-1:0]       ld_addr,
  input  logic [XLEN-1:0]     ld_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush
);

  rf_state_e         state, state_nxt;
  logic [AW-1:0]     cnt;
  logic [NREGS-1:0]  busy, busy_nxt;
  logic [XLEN-1:0]   mem [NREGS];
  logic              run, wb_we, ld_we, iss_we;

  assign run    = (state == RF_RUN);
  assign wb_we  = run && wb_en  && !((ZERO_REG != 0) && (wb_addr  == AW'(RF_ZERO_ADDR)));
  assign ld_we  = run && ld_en  && !((ZERO_REG != 0) && (ld_addr  == AW'(RF_ZERO_ADDR)));
  assign iss_we = run && iss_en && !((ZERO_REG != 0) && (iss_addr == AW'(RF_ZERO_ADDR)));

  always_comb begin
    state_nxt = state;
    case (state)
      RF_INIT: if (cnt == AW'(NREGS-1)) state_nxt = RF_RUN;
      default: state_nxt = state;
    endcase
  end

  // set after clear so a new producer keeps ownership; flush trumps both
  always_comb begin
    busy_nxt = busy;
    if (run) begin
      for (int a = 0; a < NREGS; a++) begin
        if ((wb_we && wb_addr == AW'(a)) || (ld_we && ld_addr == AW'(a))) busy_nxt[a] = 1'b0;
        if (iss_we && iss_addr == AW'(a)) busy_nxt[a] = 1'b1;
      end
      if (flush) busy_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RF_INIT;
      cnt       <= '0;
      busy      <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt == RF_RUN);
      busy      <= busy_nxt;
      if (!run) cnt <= cnt + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) mem[cnt] <= '0;
      else begin
        if (ld_we && !(wb_we && wb_addr == ld_addr)) mem[ld_addr] <= ld_data;
        if (wb_we) mem[wb_addr] <= wb_data;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rs_addr[k*AW +: AW];
    regfile_rd_bypass #(.XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG)) u_rd (
      .run      (run),
      .rd_addr  (a),
      .arr_word (mem[a]),
      .wb_we    (wb_we),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .ld_we    (ld_we),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .busy_bit (busy[a]),
      .rd_data  (rs_data[k*XLEN +: XLEN]),
      .rd_busy  (rs_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: 32x2-port and 16x3-port instances.
module tb_regfile_mp_sb;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  // instance A: NREGS=32, NRD=2
  logic        rst_a, init_a;
  logic [9:0]  rs_addr_a;
  logic [63:0] rs_data_a;
  logic [1:0]  rs_busy_a;
  logic        wb_en_a, ld_en_a, iss_en_a, flush_a;
  logic [4:0]  wb_addr_a, ld_addr_a, iss_addr_a;
  logic [31:0] wb_data_a, ld_data_a;

  // instance B: NREGS=16, NRD=3
  logic        rst_b, init_b;
  logic [11:0] rs_addr_b;
  logic [95:0] rs_data_b;
  logic [2:0]  rs_busy_b;
  logic        wb_en_b, ld_en_b, iss_en_b, flush_b;
  logic [3:0]  wb_addr_b, ld_addr_b, iss_addr_b;
  logic [31:0] wb_data_b, ld_data_b;

  regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst_a), .init_done(init_a),
    .rs_addr(rs_addr_a), .rs_data(rs_data_a), .rs_busy(rs_busy_a),
    .wb_en(wb_en_a), .wb_addr(wb_addr_a), .wb_data(wb_data_a),
    .ld_en(ld_en_a), .ld_addr(ld_addr_a), .ld_data(ld_data_a),
    .iss_en(iss_en_a), .iss_addr(iss_addr_a), .flush(flush_a)
  );

  regfile_mp_sb #(.XLEN(32), .NREGS(16), .NRD(3), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst_b), .init_done(init_b),
    .rs_addr(rs_addr_b), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
    .wb_en(wb_en_b), .wb_addr(wb_addr_b), .wb_data(wb_data_b),
    .ld_en(ld_en_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b),
    .iss_en(iss_en_b), .iss_addr(iss_addr_b), .flush(flush_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  nvec = 0;
  int  nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic void sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endfunction

  task automatic sb_pop(input logic [31:0] obs);
    sb_t e;
    if (sbq.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      e = sbq.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // drive one A read port, then check data and busy after settling
  task automatic rd_a(input int p, input int addr, input logic [31:0] ed, input logic eb,
                      input string tag);
    rs_addr_a[p*5 +: 5] = addr[4:0];
    sb_push({tag, "_d"}, ed);
    sb_push({tag, "_b"}, {31'd0, eb});
    #1;
    sb_pop(rs_data_a[p*32 +: 32]);
    sb_pop({31'd0, rs_busy_a[p]});
  endtask

  task automatic idle_a;
    wb_en_a = 0; ld_en_a = 0; iss_en_a = 0; flush_a = 0;
  endtask

  initial begin
    rst_a = 1; rst_b = 1;
    rs_addr_a = '0; rs_addr_b = '0;
    idle_a();
    wb_addr_a = 0; ld_addr_a = 0; iss_addr_a = 0; wb_data_a = 0; ld_data_a = 0;
    wb_en_b = 0; ld_en_b = 0; iss_en_b = 0; flush_b = 0;
    wb_addr_b = 0; ld_addr_b = 0; iss_addr_b = 0; wb_data_b = 0; ld_data_b = 0;

    repeat (3) step();
    sb_push("rst_init_done", 32'd0);
    sb_pop({31'd0, init_a});
    sb_push("rst_busy", 32'd0);
    sb_pop({30'd0, rs_busy_a});

    // sweep, with WB pulses that must be ignored
    rst_a = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      sb_push($sformatf("sweep_done_%0d", k), {31'd0, (k == 32)});
      sb_pop({31'd0, init_a});
      if (k == 10) begin
        rs_addr_a[4:0] = 5'd2;
        sb_push("init_rd_zero", 32'd0);
        #1 sb_pop(rs_data_a[31:0]);
      end
      if (k <= 5) begin
        wb_en_a = 1; wb_addr_a = 5'(k); wb_data_a = 32'hFFFF_FFFF;
      end else wb_en_a = 0;
    end
    for (int a = 0; a < 32; a++) rd_a(a % 2, a, 32'd0, 1'b0, $sformatf("clr_x%0d", a));

    // write, same-cycle bypass, then array read
    wb_en_a = 1; wb_addr_a = 5; wb_data_a = 32'hDEAD_BEEF;
    rd_a(0, 5, 32'hDEAD_BEEF, 0, "byp_x5");
    step(); idle_a();
    rd_a(0, 5, 32'hDEAD_BEEF, 0, "arr_x5");
    wb_en_a = 1; wb_addr_a = 0; wb_data_a = 32'h1234;
    rd_a(0, 0, 32'd0, 0, "x0_byp");
    step(); idle_a();
    rd_a(1, 0, 32'd0, 0, "x0_arr");

    // collision: WB wins
    wb_en_a = 1; wb_addr_a = 7; wb_data_a = 32'hAAAA_0000;
    ld_en_a = 1; ld_addr_a = 7; ld_data_a = 32'h5555_FFFF;
    rd_a(0, 7, 32'hAAAA_0000, 0, "col_byp");
    step(); idle_a();
    rd_a(1, 7, 32'hAAAA_0000, 0, "col_arr");
    wb_en_a = 1; wb_addr_a = 8; wb_data_a = 32'h1111_1111;
    ld_en_a = 1; ld_addr_a = 9; ld_data_a = 32'h2222_2222;
    rd_a(1, 9, 32'h2222_2222, 0, "ld_byp_x9");
    step(); idle_a();
    rd_a(0, 8, 32'h1111_1111, 0, "wb_x8");
    rd_a(1, 9, 32'h2222_2222, 0, "ld_x9");

    // scoreboard: set, set-wins, clear
    iss_en_a = 1; iss_addr_a = 3;
    step(); idle_a();
    rd_a(0, 3, 32'd0, 1, "iss_x3");
    iss_en_a = 1; iss_addr_a = 3; ld_en_a = 1; ld_addr_a = 3; ld_data_a = 32'h42;
    rd_a(1, 3, 32'h42, 0, "ld_iss_byp");
    step(); idle_a();
    rd_a(0, 3, 32'h42, 1, "set_wins");
    wb_en_a = 1; wb_addr_a = 3; wb_data_a = 32'h99;
    step(); idle_a();
    rd_a(0, 3, 32'h99, 0, "wb_clr_x3");

    // flush overrides a same-cycle issue
    iss_en_a = 1; iss_addr_a = 1; step();
    iss_addr_a = 2; step();
    iss_addr_a = 4; step();
    idle_a();
    rd_a(0, 1, 32'd0, 1, "pre_fl_x1");
    rd_a(1, 4, 32'd0, 1, "pre_fl_x4");
    iss_en_a = 1; iss_addr_a = 6; flush_a = 1;
    step(); idle_a();
    rd_a(0, 1, 32'd0, 0, "fl_x1");
    rd_a(1, 2, 32'd0, 0, "fl_x2");
    rd_a(0, 4, 32'd0, 0, "fl_x4");
    rd_a(1, 6, 32'd0, 0, "fl_x6");

    // mid-run reset restarts the sweep
    wb_en_a = 1; wb_addr_a = 10; wb_data_a = 32'hFFFF_FFFF;
    iss_en_a = 1; iss_addr_a = 11;
    step(); idle_a();
    rd_a(0, 10, 32'hFFFF_FFFF, 0, "pre_rst_x10");
    rd_a(1, 11, 32'd0, 1, "pre_rst_x11");
    rst_a = 1; step(); rst_a = 0;
    sb_push("mid_rst_drop", 32'd0);
    sb_pop({31'd0, init_a});
    for (int k = 1; k <= 32; k++) begin
      step();
      sb_push($sformatf("resweep_%0d", k), {31'd0, (k == 32)});
      sb_pop({31'd0, init_a});
    end
    rd_a(0, 10, 32'd0, 0, "post_rst_x10");
    rd_a(1, 11, 32'd0, 0, "post_rst_x11");

    // instance B: 16-entry sweep, three bypassed ports
    rst_b = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      sb_push($sformatf("b_sweep_%0d", k), {31'd0, (k == 16)});
      sb_pop({31'd0, init_b});
    end
    wb_en_b = 1; wb_addr_b = 5; wb_data_b = 32'hCAFE_F00D;
    ld_en_b = 1; ld_addr_b = 6; ld_data_b = 32'h0BAD_F00D;
    rs_addr_b = {4'd5, 4'd6, 4'd5};
    sb_push("b_byp_p0", 32'hCAFE_F00D);
    sb_push("b_byp_p1", 32'h0BAD_F00D);
    sb_push("b_byp_p2", 32'hCAFE_F00D);
    #1;
    for (int p = 0; p < 3; p++) sb_pop(rs_data_b[p*32 +: 32]);
    step();
    wb_en_b = 0; ld_en_b = 0;
    rs_addr_b = {4'd6, 4'd5, 4'd6};
    sb_push("b_arr_p0", 32'h0BAD_F00D);
    sb_push("b_arr_p1", 32'hCAFE_F00D);
    sb_push("b_arr_p2", 32'h0BAD_F00D);
    #1;
    for (int p = 0; p < 3; p++) sb_pop(rs_data_b[p*32 +: 32]);

    if (sbq.size() != 0) chk("sb_leftover", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
